cordic_iter_seq: RTL and testbench
==================================

CORDIC_ITER_SEQ -- requirements
Module: cordic_iter_seq

Interface
REQ-001 The block SHALL have parameter W, default 4: width of the iteration index.
REQ-002 The block SHALL have parameter N_ITER, default 13: CORDIC iterations per operation; legal range 1..2^W-1.
REQ-003 Port clk SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be: input, 1 bit, asynchronous active-high reset.
REQ-005 Port start SHALL be: input, 1 bit, operation request; sampled only in IDLE.
REQ-006 Port ack SHALL be: input, 1 bit, consumer accepts the result; sampled only in DONE.
REQ-007 Port ready SHALL be: output, 1 bit, high in IDLE.
REQ-008 Port busy SHALL be: output, 1 bit, high in LOAD and ITER.
REQ-009 Port load_init SHALL be: output, 1 bit, loads the initial x/y/z datapath registers.
REQ-010 Port sel_init SHALL be: output, 1 bit, selects initial operands, not feedback, at the datapath mux.
REQ-011 Port iter_en SHALL be: output, 1 bit, enables one datapath micro-rotation update.
REQ-012 Port iter_idx SHALL be: output, W bits, current iteration index; drives the shift amount and the atan LUT address.
REQ-013 Port last_iter SHALL be: output, 1 bit, flags the final iteration.
REQ-014 Port done SHALL be: output, 1 bit, result valid; held until ack.

Function
REQ-015 The FSM SHALL have exactly four states, IDLE, LOAD, ITER and DONE, with Moore outputs and no combinational path from any input to any output.
REQ-016 In IDLE, start=1 SHALL cause a transition to LOAD on the next edge; start=0 SHALL keep the FSM in IDLE.
REQ-017 LOAD SHALL last exactly one cycle, with load_init=1, sel_init=1, iter_idx=0 and the iteration counter cleared, followed by an unconditional transition to ITER.
REQ-018 In ITER, iter_en SHALL be 1 every cycle and iter_idx SHALL step 0,1,...,N_ITER-1, incrementing by one per cycle.
REQ-019 last_iter SHALL be 1 only in ITER when iter_idx==N_ITER-1; on that cycle the FSM SHALL transition to DONE.
REQ-020 In DONE, done SHALL be 1 and iter_idx SHALL hold N_ITER-1; ack=1 SHALL cause a transition to IDLE on the next edge.
REQ-021 start asserted outside IDLE SHALL be ignored, not queued.
REQ-022 ack asserted outside DONE SHALL be ignored.
REQ-023 start and ack both high in DONE SHALL return the FSM to IDLE only; a new operation requires start in IDLE.
REQ-024 Latency SHALL be fixed: with start sampled at edge k, done SHALL first be high in the cycle after edge k+N_ITER+1.
REQ-025 For N_ITER=1, ITER SHALL last one cycle with iter_idx=0 and last_iter=1.
REQ-026 The iteration counter SHALL never exceed N_ITER-1 and SHALL never wrap.
REQ-027 Outputs not listed as active for a state SHALL be 0 in that state.

Reset
REQ-028 rst=1 SHALL immediately force IDLE and counter=0, giving ready=1 and busy, load_init, sel_init, iter_en, last_iter, done=0, iter_idx=0.
REQ-029 Reset mid-operation SHALL abort the operation with no done pulse; the next start after reset release SHALL run a full operation.

Structure
REQ-030 The state encoding (IDLE, LOAD, ITER, DONE) and the N_ITER default SHALL be defined in shared package cordic_pkg.
REQ-031 The iteration counter SHALL be sub-module cordic_iter_counter, with synchronous clear, enable and terminal flag at N_ITER-1; the FSM SHALL be in the top level.

Verification (W=4, N_ITER=4)
REQ-032 A bench SHALL cover: start=1 for one cycle from IDLE -> load_init for one cycle, then iter_idx 0,1,2,3 with iter_en=1 and last_iter only at 3, then done=1 held.
REQ-033 A bench SHALL cover: done=1 with ack=0 for 5 cycles -> done stays 1 and iter_idx=3; ack=1 -> ready=1 on the next cycle.
REQ-034 A bench SHALL cover: start pulsed during ITER at iter_idx=1 -> no effect; exactly one done; the FSM returns to IDLE after ack.
REQ-035 A bench SHALL cover: rst asserted at iter_idx=2 -> all outputs reach their reset values immediately; no done; a fresh start completes in the same latency.
REQ-036 A bench SHALL cover: start and ack both high in DONE -> IDLE next cycle, no LOAD; start the following cycle -> LOAD.
REQ-037 A bench SHALL cover: N_ITER=1 build with start -> one ITER cycle with iter_idx=0 and last_iter=1, then done.

Source files
------------

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared state encoding and defaults for the CORDIC sequencer
package cordic_pkg;

    localparam int W_DEFAULT      = 4;
    localparam int N_ITER_DEFAULT = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } cordic_state_e;

endpackage

// File: rtl/cordic_iter_counter.sv
// rtl/cordic_iter_counter.sv - iteration index counter with sync clear, enable and terminal flag
module cordic_iter_counter
    import cordic_pkg::*;
#(
    parameter int W      = W_DEFAULT,
    parameter int N_ITER = N_ITER_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         term_o
);

    localparam logic [W-1:0] LAST_IDX = W'(N_ITER - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Saturates at the terminal index so the count can never wrap.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LAST_IDX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign term_o  = (count_q == LAST_IDX);

endmodule

// File: rtl/cordic_iter_seq.sv
// rtl/cordic_iter_seq.sv - Moore FSM sequencing load and micro-rotations of a CORDIC datapath
module cordic_iter_seq
    import cordic_pkg::*;
#(
    parameter int W      = W_DEFAULT,
    parameter int N_ITER = N_ITER_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         ack,
    output logic         ready,
    output logic         busy,
    output logic         load_init,
    output logic         sel_init,
    output logic         iter_en,
    output logic [W-1:0] iter_idx,
    output logic         last_iter,
    output logic         done
);

    cordic_state_e state_q;
    cordic_state_e state_d;

    logic [W-1:0] cnt;
    logic         cnt_term;

    cordic_iter_counter #(
        .W      (W),
        .N_ITER (N_ITER)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .clr_i   ((state_q == ST_IDLE) || (state_q == ST_LOAD)),
        .en_i    (state_q == ST_ITER),
        .count_o (cnt),
        .term_o  (cnt_term)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start)    state_d = ST_LOAD;
            ST_LOAD:               state_d = ST_ITER;
            ST_ITER: if (cnt_term) state_d = ST_DONE;
            ST_DONE: if (ack)      state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs depend only on registered state, never on start/ack.
    assign ready     = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_ITER);
    assign load_init = (state_q == ST_LOAD);
    assign sel_init  = (state_q == ST_LOAD);
    assign iter_en   = (state_q == ST_ITER);
    assign last_iter = (state_q == ST_ITER) && cnt_term;
    assign done      = (state_q == ST_DONE);
    assign iter_idx  = ((state_q == ST_ITER) || (state_q == ST_DONE)) ? cnt : '0;

endmodule

// File: tb/tb_cordic_iter_seq.sv
// tb/tb_cordic_iter_seq.sv - randomized and directed check of cordic_iter_seq against a timeline model
module tb_cordic_iter_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ack = 1'b0;

    logic       rdy4, bsy4, ld4, sel4, ien4, lst4, dn4;
    logic [3:0] idx4;
    logic       rdy1, bsy1, ld1, sel1, ien1, lst1, dn1;
    logic [3:0] idx1;

    int checks = 0;
    int errors = 0;

    // Operation timeline: -1 idle, 0 load, 1..n iterating, n+1 result held.
    int m4 = -1;
    int m1 = -1;

    always #5 clk = ~clk;

    cordic_iter_seq #(.W(4), .N_ITER(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .ack(ack),
        .ready(rdy4), .busy(bsy4), .load_init(ld4), .sel_init(sel4),
        .iter_en(ien4), .iter_idx(idx4), .last_iter(lst4), .done(dn4)
    );

    cordic_iter_seq #(.W(4), .N_ITER(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .ack(ack),
        .ready(rdy1), .busy(bsy1), .load_init(ld1), .sel_init(sel1),
        .iter_en(ien1), .iter_idx(idx1), .last_iter(lst1), .done(dn1)
    );

    function automatic int advance(input int t, input int n, input logic s, input logic a);
        if (t < 0)      return s ? 0 : -1;
        else if (t <= n) return t + 1;
        else            return a ? -1 : t;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m4 <= -1;
            m1 <= -1;
        end else begin
            m4 <= advance(m4, 4, start, ack);
            m1 <= advance(m1, 1, start, ack);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_dut(input string p, input int n, input int t,
                             input logic rdy, input logic bsy, input logic ld,
                             input logic sel, input logic ien, input logic [3:0] idx,
                             input logic lst, input logic dn);
        int e_idx;
        e_idx = (t < 1) ? 0 : ((t - 1 < n) ? t - 1 : n - 1);
        check({p, ".ready"},     int'(rdy), int'(t == -1));
        check({p, ".busy"},      int'(bsy), int'(t >= 0 && t <= n));
        check({p, ".load_init"}, int'(ld),  int'(t == 0));
        check({p, ".sel_init"},  int'(sel), int'(t == 0));
        check({p, ".iter_en"},   int'(ien), int'(t >= 1 && t <= n));
        check({p, ".iter_idx"},  int'(idx), e_idx);
        check({p, ".last_iter"}, int'(lst), int'(t == n));
        check({p, ".done"},      int'(dn),  int'(t == n + 1));
    endtask

    task automatic check_all();
        check_dut("n4", 4, m4, rdy4, bsy4, ld4, sel4, ien4, idx4, lst4, dn4);
        check_dut("n1", 1, m1, rdy1, bsy1, ld1, sel1, ien1, idx1, lst1, dn1);
    endtask

    task automatic cyc(input logic s, input logic a);
        start = s;
        ack   = a;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int lat;
        #1;
        check_all();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // Full operation, then result held without ack.
        cyc(1, 0);
        repeat (5) cyc(0, 0);
        check("n4.done_reached", int'(dn4), 1);
        repeat (5) cyc(0, 0);
        check("n4.idx_held", int'(idx4), 3);
        cyc(0, 1);
        check("n4.ready_after_ack", int'(rdy4), 1);

        // Start pulsed mid-iteration is ignored.
        cyc(1, 0);
        cyc(0, 0);
        cyc(0, 0);
        cyc(1, 0);
        repeat (4) cyc(0, 0);
        cyc(0, 1);
        repeat (3) cyc(0, 0);
        check("n4.idle_no_requeue", int'(rdy4), 1);

        // Reset at iter_idx 2 aborts immediately.
        cyc(1, 0);
        repeat (3) cyc(0, 0);
        check("n4.pre_reset_idx", int'(idx4), 2);
        rst = 1'b1;
        #1;
        check_all();
        check("n4.reset_ready", int'(rdy4), 1);
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // Fresh start after reset keeps the fixed latency.
        start = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_all();
            start = 1'b0;
            lat++;
            if (dn4) break;
        end
        check("n4.latency", lat, 6);

        // start and ack together in DONE only returns to idle.
        cyc(1, 1);
        check("n4.idle_not_load", int'(ld4), 0);
        cyc(1, 0);
        check("n4.load_after_start", int'(ld4), 1);
        repeat (6) cyc(0, 0);
        cyc(0, 1);

        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
